// File: rtl/song_mem_ctrl_pkg.sv
// Shared definitions for the song memory controller: FSM encodings and
// default geometry of the song memory (16 regions of 2**REGION_W samples).
package song_mem_ctrl_pkg;
   localparam int REGION_W_DFLT = 15;
   localparam int DATA_W_DFLT   = 8;
   localparam int NUM_SONGS     = 16;
   localparam int SONG_W        = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_RDWAIT = 2'd2
   } state_t;
endpackage

// File: rtl/song_mem_ctrl_len.sv
// Per-song length table: one write port, combinational read by song index.
// Reset restores every entry to a full region so unrecorded songs play whole.
module song_len_table
   import song_mem_ctrl_pkg::*;
#(
   parameter int REGION_W = REGION_W_DFLT
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_we,
   input  logic [SONG_W-1:0]   i_wsel,
   input  logic [REGION_W:0]   i_wlen,
   input  logic [SONG_W-1:0]   i_rsel,
   output logic [REGION_W:0]   o_rlen
);
   localparam logic [REGION_W:0] FULL_LEN = {1'b1, {REGION_W{1'b0}}};

   logic [REGION_W:0] r_len [NUM_SONGS];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_SONGS; i++) r_len[i] <= FULL_LEN;
      end else if (i_we) begin
         r_len[i_wsel] <= i_wlen;
      end
   end

   assign o_rlen = r_len[i_rsel];
endmodule

// File: rtl/song_mem_ctrl.sv
// Sequences record/playback accesses into the song memory, one per AC97
// ready strobe, and pulses song_done at end of song or end of region.
module song_mem_ctrl
   import song_mem_ctrl_pkg::*;
#(
   parameter int REGION_W = REGION_W_DFLT,
   parameter int DATA_W   = DATA_W_DFLT,
   parameter int ADDR_W   = SONG_W + REGION_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ready,
   input  logic              record_mode,
   input  logic [SONG_W-1:0] song_choice,
   input  logic              start_song,
   input  logic              pause_song,
   input  logic [DATA_W-1:0] rec_sample,
   input  logic [DATA_W-1:0] mem_dout,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_din,
   output logic [DATA_W-1:0] play_sample,
   output logic              song_done,
   output logic              busy
);
   // Offset carries one extra bit so offset+1 can equal a full-region length.
   localparam logic [REGION_W:0] LAST_OFF = {1'b0, {REGION_W{1'b1}}};

   state_t              r_state, w_state_nxt;
   logic                r_mode, w_mode_nxt;
   logic [SONG_W-1:0]   r_song, w_song_nxt;
   logic [REGION_W:0]   r_off, w_off_nxt, w_off_inc;
   logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
   logic                r_we, w_we_nxt;
   logic [DATA_W-1:0]   r_din, w_din_nxt;
   logic [DATA_W-1:0]   r_play, w_play_nxt;
   logic                r_done, w_done_nxt;
   logic                w_len_we;
   logic [REGION_W:0]   w_len;

   song_len_table #(.REGION_W(REGION_W)) u_len (
      .clk    (clk),
      .reset  (reset),
      .i_we   (w_len_we),
      .i_wsel (r_song),
      .i_wlen (w_off_inc),
      .i_rsel (r_song),
      .o_rlen (w_len)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_mode  <= 1'b0;
         r_song  <= '0;
         r_off   <= '0;
         r_addr  <= '0;
         r_we    <= 1'b0;
         r_din   <= '0;
         r_play  <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_mode  <= w_mode_nxt;
         r_song  <= w_song_nxt;
         r_off   <= w_off_nxt;
         r_addr  <= w_addr_nxt;
         r_we    <= w_we_nxt;
         r_din   <= w_din_nxt;
         r_play  <= w_play_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_mode_nxt  = r_mode;
      w_song_nxt  = r_song;
      w_off_nxt   = r_off;
      w_addr_nxt  = r_addr;
      w_din_nxt   = r_din;
      w_play_nxt  = r_play;
      w_we_nxt    = 1'b0;
      w_done_nxt  = 1'b0;
      w_len_we    = 1'b0;
      w_off_inc   = r_off + 1'b1;

      // A start always wins, including over a coincident ready strobe.
      if (start_song) begin
         w_mode_nxt  = record_mode;
         w_song_nxt  = song_choice;
         w_off_nxt   = '0;
         w_state_nxt = ST_RUN;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_play_nxt = '0;
            end
            ST_RUN: begin
               if (pause_song) begin
                  w_play_nxt = '0;
               end else if (!r_mode && w_len == '0) begin
                  w_done_nxt  = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else if (ready) begin
                  w_addr_nxt = {r_song, r_off[REGION_W-1:0]};
                  if (r_mode) begin
                     w_din_nxt = rec_sample;
                     w_we_nxt  = 1'b1;
                     w_len_we  = 1'b1;
                     w_off_nxt = w_off_inc;
                     if (r_off == LAST_OFF) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                     end
                  end else begin
                     w_state_nxt = ST_RDWAIT;
                  end
               end
            end
            ST_RDWAIT: begin
               w_play_nxt = mem_dout;
               w_off_nxt  = w_off_inc;
               if (w_off_inc >= w_len) begin
                  w_done_nxt  = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_state_nxt = ST_RUN;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   assign mem_addr    = r_addr;
   assign mem_we      = r_we;
   assign mem_din     = r_din;
   assign play_sample = r_play;
   assign song_done   = r_done;
   assign busy        = (r_state != ST_IDLE);
endmodule

// File: tb/tb_song_mem_ctrl.sv
// Directed bench for song_mem_ctrl with 8-sample regions and a behavioural
// song memory (combinational read, write on the clock edge).
module tb_song_mem_ctrl;
   localparam int RW = 3;
   localparam int DW = 8;
   localparam int AW = 7;

   logic          clk = 1'b0;
   logic          reset, ready, record_mode, start_song, pause_song;
   logic [3:0]    song_choice;
   logic [DW-1:0] rec_sample, mem_dout, mem_din, play_sample;
   logic [AW-1:0] mem_addr;
   logic          mem_we, song_done, busy;
   logic          tb_init, wrote_38;
   logic [7:0]    mem [128];
   int            n_vec = 0;
   int            n_bad = 0;

   always #5 clk = ~clk;

   song_mem_ctrl #(.REGION_W(RW), .DATA_W(DW), .ADDR_W(AW)) dut (
      .clk         (clk),
      .reset       (reset),
      .ready       (ready),
      .record_mode (record_mode),
      .song_choice (song_choice),
      .start_song  (start_song),
      .pause_song  (pause_song),
      .rec_sample  (rec_sample),
      .mem_dout    (mem_dout),
      .mem_addr    (mem_addr),
      .mem_we      (mem_we),
      .mem_din     (mem_din),
      .play_sample (play_sample),
      .song_done   (song_done),
      .busy        (busy)
   );

   always @(posedge clk) begin
      if (tb_init) for (int i = 0; i < 128; i++) mem[i] <= 8'(i);
      else if (mem_we) mem[mem_addr] <= mem_din;
   end
   assign mem_dout = mem[mem_addr];

   always @(posedge clk) begin
      if (tb_init) wrote_38 <= 1'b0;
      else if (mem_we && mem_addr == 7'h38) wrote_38 <= 1'b1;
   end

   typedef struct {
      logic       rst, rdy, rec;
      logic [3:0] song;
      logic       start, pause;
      logic [7:0] smp;
      logic [6:0] addr;
      logic       we;
      logic [7:0] din, play;
      logic       done, bsy;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic rst, rdy, rec, input logic [3:0] song,
                               input logic start, pause, input logic [7:0] smp,
                               input logic [6:0] addr, input logic we,
                               input logic [7:0] din, play, input logic done, bsy);
      vec_t v;
      v.rst = rst; v.rdy = rdy; v.rec = rec; v.song = song; v.start = start;
      v.pause = pause; v.smp = smp; v.addr = addr; v.we = we; v.din = din;
      v.play = play; v.done = done; v.bsy = bsy;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, input int idx);
      reset = v.rst; ready = v.rdy; record_mode = v.rec; song_choice = v.song;
      start_song = v.start; pause_song = v.pause; rec_sample = v.smp;
      tick();
      n_vec++;
      if ({mem_addr, mem_we, mem_din, play_sample, song_done, busy} !==
          {v.addr, v.we, v.din, v.play, v.done, v.bsy}) begin
         n_bad++;
         $display("FAIL vec%0d: got addr=%h we=%b din=%h play=%h done=%b busy=%b, want addr=%h we=%b din=%h play=%h done=%b busy=%b",
                  idx, mem_addr, mem_we, mem_din, play_sample, song_done, busy,
                  v.addr, v.we, v.din, v.play, v.done, v.bsy);
      end
   endtask

   initial begin
      logic [7:0] e6 [8];
      e6 = '{8'hC0, 8'hC1, 8'h13, 8'h14, 8'h15, 8'h1D, 8'h1E, 8'h1F};
      reset = 1'b1; tb_init = 1'b1; ready = 1'b0; record_mode = 1'b0;
      song_choice = '0; start_song = 1'b0; pause_song = 1'b0; rec_sample = '0;
      tick(); tick();
      tb_init = 1'b0;

      // rst rdy rec song st pz smp | addr we din play done busy
      vecs.push_back(mk(1,0,0,0,0,0,8'h00, 7'h00,0,8'h00,8'h00,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,8'h00, 7'h00,0,8'h00,8'h00,0,0));
      // record song 3, five samples
      vecs.push_back(mk(0,0,1,3,1,0,8'h00, 7'h00,0,8'h00,8'h00,0,1));
      vecs.push_back(mk(0,1,1,3,0,0,8'h11, 7'h18,1,8'h11,8'h00,0,1));
      vecs.push_back(mk(0,0,1,3,0,0,8'h00, 7'h18,0,8'h11,8'h00,0,1));
      vecs.push_back(mk(0,1,1,3,0,0,8'h12, 7'h19,1,8'h12,8'h00,0,1));
      vecs.push_back(mk(0,0,1,3,0,0,8'h00, 7'h19,0,8'h12,8'h00,0,1));
      vecs.push_back(mk(0,1,1,3,0,0,8'h13, 7'h1A,1,8'h13,8'h00,0,1));
      vecs.push_back(mk(0,1,1,3,0,0,8'h14, 7'h1B,1,8'h14,8'h00,0,1));
      vecs.push_back(mk(0,1,1,3,0,0,8'h15, 7'h1C,1,8'h15,8'h00,0,1));
      vecs.push_back(mk(0,0,1,3,0,0,8'h00, 7'h1C,0,8'h15,8'h00,0,1));
      // play song 3 back, restarting from RUN
      vecs.push_back(mk(0,0,0,3,1,0,8'h00, 7'h1C,0,8'h15,8'h00,0,1));
      vecs.push_back(mk(0,0,0,3,0,0,8'h00, 7'h1C,0,8'h15,8'h00,0,1));
      vecs.push_back(mk(0,1,0,3,0,0,8'h00, 7'h18,0,8'h15,8'h00,0,1));
      vecs.push_back(mk(0,0,0,3,0,0,8'h00, 7'h18,0,8'h15,8'h11,0,1));
      vecs.push_back(mk(0,1,0,3,0,0,8'h00, 7'h19,0,8'h15,8'h11,0,1));
      vecs.push_back(mk(0,0,0,3,0,0,8'h00, 7'h19,0,8'h15,8'h12,0,1));
      vecs.push_back(mk(0,1,0,3,0,0,8'h00, 7'h1A,0,8'h15,8'h12,0,1));
      vecs.push_back(mk(0,0,0,3,0,0,8'h00, 7'h1A,0,8'h15,8'h13,0,1));
      vecs.push_back(mk(0,1,0,3,0,0,8'h00, 7'h1B,0,8'h15,8'h13,0,1));
      vecs.push_back(mk(0,0,0,3,0,0,8'h00, 7'h1B,0,8'h15,8'h14,0,1));
      vecs.push_back(mk(0,1,0,3,0,0,8'h00, 7'h1C,0,8'h15,8'h14,0,1));
      vecs.push_back(mk(0,0,0,3,0,0,8'h00, 7'h1C,0,8'h15,8'h15,1,0));
      vecs.push_back(mk(0,0,0,3,0,0,8'h00, 7'h1C,0,8'h15,8'h00,0,0));
      // start and ready together: no access until the next strobe
      vecs.push_back(mk(0,1,1,5,1,0,8'h66, 7'h1C,0,8'h15,8'h00,0,1));
      vecs.push_back(mk(0,0,1,5,0,0,8'h00, 7'h1C,0,8'h15,8'h00,0,1));
      vecs.push_back(mk(0,1,1,5,0,0,8'h77, 7'h28,1,8'h77,8'h00,0,1));
      vecs.push_back(mk(0,0,1,5,0,0,8'h00, 7'h28,0,8'h77,8'h00,0,1));

      foreach (vecs[i]) apply(vecs[i], i);
      ready = 1'b0; start_song = 1'b0;

      // pause holds the record position of song 5 (offset 1)
      pause_song = 1'b1;
      for (int k = 0; k < 3; k++) begin
         ready = 1'b1; rec_sample = 8'h80 + 8'(k);
         tick();
         chk("pause_we", 32'(mem_we), 32'h0);
         chk("pause_addr", 32'(mem_addr), 32'h28);
         ready = 1'b0;
         tick();
      end
      chk("pause_busy", 32'(busy), 32'h1);
      pause_song = 1'b0; ready = 1'b1; rec_sample = 8'h90;
      tick();
      chk("resume_addr", 32'(mem_addr), 32'h29);
      chk("resume_we", 32'(mem_we), 32'h1);
      chk("resume_din", 32'(mem_din), 32'h90);
      ready = 1'b0;
      tick();

      // record song 6 to the end of its region
      record_mode = 1'b1; song_choice = 4'd6; start_song = 1'b1;
      tick();
      start_song = 1'b0;
      for (int k = 0; k < 8; k++) begin
         ready = 1'b1; rec_sample = 8'hA0 + 8'(k);
         tick();
         chk("reg_addr", 32'(mem_addr), 32'h30 + 32'(k));
         chk("reg_we", 32'(mem_we), 32'h1);
         chk("reg_done", 32'(song_done), (k == 7) ? 32'h1 : 32'h0);
         ready = 1'b0;
         tick();
         chk("reg_we_off", 32'(mem_we), 32'h0);
      end
      chk("reg_done_pulse", 32'(song_done), 32'h0);
      chk("reg_busy", 32'(busy), 32'h0);
      ready = 1'b1;
      tick();
      chk("reg_no_wrap_we", 32'(mem_we), 32'h0);
      ready = 1'b0;
      tick();
      chk("reg_no_wrap_38", 32'(wrote_38), 32'h0);

      // reset in the middle of a record of song 3
      record_mode = 1'b1; song_choice = 4'd3; start_song = 1'b1;
      tick();
      start_song = 1'b0;
      for (int k = 0; k < 2; k++) begin
         ready = 1'b1; rec_sample = 8'hC0 + 8'(k);
         tick();
         ready = 1'b0;
         tick();
      end
      ready = 1'b1; rec_sample = 8'hC2; reset = 1'b1;
      tick();
      chk("rst_we", 32'(mem_we), 32'h0);
      chk("rst_addr", 32'(mem_addr), 32'h0);
      chk("rst_din", 32'(mem_din), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      reset = 1'b0; ready = 1'b0;
      tick();
      chk("rst_drop", 32'(mem[7'h1A]), 32'h13);

      // playback of song 3 now runs the full region
      record_mode = 1'b0; start_song = 1'b1;
      tick();
      start_song = 1'b0;
      chk("full_done_after_start", 32'(song_done), 32'h0);
      tick();
      for (int k = 0; k < 8; k++) begin
         ready = 1'b1;
         tick();
         chk("full_addr", 32'(mem_addr), 32'h18 + 32'(k));
         ready = 1'b0;
         tick();
         chk("full_play", 32'(play_sample), 32'(e6[k]));
         chk("full_done", 32'(song_done), (k == 7) ? 32'h1 : 32'h0);
      end
      tick();
      chk("full_done_pulse", 32'(song_done), 32'h0);
      chk("full_busy", 32'(busy), 32'h0);
      chk("full_silence", 32'(play_sample), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
